csi2_llp_packet_parser: RTL and testbench
=========================================

Name: csi2_llp_packet_parser

Overview:
- Upstream neighbour of the byte-to-pixel stage.
- Receives the merged CSI-2 byte stream from the lane-merge stage. Parses the 4-byte packet header (DI, WC LSB, WC MSB, ECC) and checks it with the CSI-2 Hamming ECC.
- Forwards long-packet payload bytes and checks the trailing CRC-16.
- Drives the vc/id/wc/data_in_llp/data_valid/ecc_error2/crc_detect inputs of the pixel stage.

Parameters:
- MAX_WC, 16'hFFFF, largest legal word count. A header WC above this is treated as an ECC-class fatal error (ecc_error2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- byte_in  in  8  merged lane byte.
- byte_valid  in  1  byte_in is valid this cycle.
- pkt_start  in  1  marks the DI byte of a new packet. Sampled only with byte_valid.
- vc  out  2  virtual channel (DI[7:6]).
- id  out  8  data type, {2'b00, DI[5:0]}.
- wc  out  16  word count or short-packet data field.
- data_in_llp  out  8  payload byte.
- data_valid  out  1  data_in_llp valid.
- ecc_error1  out  1  single-bit header error was corrected (sticky per packet).
- ecc_error2  out  1  uncorrectable header error (sticky per packet).
- crc_detect  out  1  payload CRC mismatch (sticky per packet).
- pkt_done  out  1  one-cycle pulse at end of packet.

Behaviour:
- Reset: all outputs 0, except id = 8'hFF (no packet). State = IDLE. Internal CRC register = 16'hFFFF.
- IDLE: waits for byte_valid & pkt_start, then captures DI and moves to HDR.
- Any pkt_start in any other state aborts the current packet and restarts the header with that byte. No pkt_done is issued for the aborted packet.
- HDR: captures WC LSB, WC MSB, then the ECC byte, one per valid byte. Cycles where byte_valid = 0 stall the state machine without loss.
- CHECK (1 cycle): computes the 6-bit syndrome over the 24 header bits. ECC bits 7:6 must be 0; if not, set ecc_error2.
  - Syndrome 0: header is clean.
  - Syndrome matches a single data-bit column: flip that bit and set ecc_error1.
  - Syndrome matches a parity-bit position: set ecc_error1, no data change.
  - Any other syndrome: set ecc_error2.
  - Then register vc/id/wc. They are stable from the cycle after CHECK until the next CHECK.
- DT <= 0x0F is a short packet: go to DONE.
- Otherwise it is a long packet:
  - wc == 0: go to CRC_LO.
  - ecc_error2: go to DONE. Payload is dropped and data_valid stays 0.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - Each valid byte: data_in_llp <= byte_in, data_valid <= 1 on the next cycle. Latency from byte_in to data_in_llp is 1 cycle.
  - CRC update: polynomial x^16+x^12+x^5+1, reflected (0x8408), LSB-first, seed 16'hFFFF.
  - A 16-bit byte counter runs; after wc bytes, go to CRC_LO.
  - data_valid is 0 in all other states.
- CRC_LO, CRC_HI: capture the received CRC, LSB first. After CRC_HI, compare against the computed CRC; a mismatch sets crc_detect. Then go to DONE.
- DONE (1 cycle): pulse pkt_done, reseed the CRC, return to IDLE.
- Error flags clear at the next packet's CHECK. vc/id/wc hold until then.
- Counter wrap: wc = 16'hFFFF is legal. The counter is 17 bits internally, so it never wraps.
- Reset mid-packet: immediate return to IDLE with reset values. The partial packet is discarded.

Optional Feature:
- CSI2_ECC_CORRECT_EN
  - Defined: single-bit header errors are corrected as above, and ecc_error1 reports them.
  - Undefined: any nonzero syndrome sets ecc_error2, the header is not modified, ecc_error1 is tied to 0, and long-packet payload is dropped.

Test Plan:
- Frame start: bytes 00 00 00 00 with pkt_start -> id=0x00, vc=0, wc=0x0000, no error flags, pkt_done 1 cycle after CHECK.
- Single-bit error: bytes 01 00 00 00 (syndrome 0x07, DI bit0 flipped) with CSI2_ECC_CORRECT_EN defined -> id=0x00, ecc_error1=1, ecc_error2=0. Same stimulus with the macro undefined -> ecc_error2=1.
- RAW8 long packet: DT 0x2A, vc=1, wc=4, payload 11 22 33 44, CRC from the bench model -> four data_valid pulses with data_in_llp 11, 22, 33, 44 each one cycle after its input; crc_detect=0.
- Same RAW8 packet with the CRC LSB inverted -> crc_detect=1 at DONE; all four payload bytes still delivered.
- RAW10 packet (DT 0x2B, wc=5) with byte_valid deasserted for 3 cycles mid-payload -> no byte lost or duplicated, exactly 5 data_valid pulses.
- reset asserted during payload byte 2 -> all outputs return to reset values immediately. Next frame-start packet parses cleanly.

Source files
------------

// File: rtl/csi2_llp_packet_parser.sv
// CSI-2 low-level packet parser.
// Collects the 4-byte packet header (DI, WC LSB, WC MSB, ECC) and checks it
// with the CSI-2 Hamming ECC. Forwards long-packet payload and verifies the
// trailing CRC-16 (reflected 0x8408, seed 0xFFFF).
// Optional feature macro: CSI2_ECC_CORRECT_EN. When it is defined, single-bit
// header errors are corrected. When it is undefined, any nonzero syndrome is
// fatal and the header is left unmodified.
module csi2_llp_packet_parser #(
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        pkt_start,
    output logic [1:0]  vc,
    output logic [7:0]  id,
    output logic [15:0] wc,
    output logic [7:0]  data_in_llp,
    output logic        data_valid,
    output logic        ecc_error1,
    output logic        ecc_error2,
    output logic        crc_detect,
    output logic        pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CHECK, S_PAYLOAD, S_CRC_LO, S_CRC_HI, S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  hdr_idx;
    logic [7:0]  di_r, wcl_r, wch_r, ecc_r, crc_lo_r;
    logic [15:0] crc_r;
    logic [16:0] byte_cnt;

    logic [23:0] hdr_d;
    logic [23:0] chk_hdr;
    logic [5:0]  syn;
    logic        chk_err1;
    logic        chk_err2;

    // Syndrome produced by a single flipped header data bit (parity columns).
    function automatic logic [5:0] ecc_col(input logic [4:0] i);
        case (i)
            5'd0:  ecc_col = 6'h07;
            5'd1:  ecc_col = 6'h0B;
            5'd2:  ecc_col = 6'h0D;
            5'd3:  ecc_col = 6'h0E;
            5'd4:  ecc_col = 6'h13;
            5'd5:  ecc_col = 6'h15;
            5'd6:  ecc_col = 6'h16;
            5'd7:  ecc_col = 6'h19;
            5'd8:  ecc_col = 6'h1A;
            5'd9:  ecc_col = 6'h1C;
            5'd10: ecc_col = 6'h23;
            5'd11: ecc_col = 6'h25;
            5'd12: ecc_col = 6'h26;
            5'd13: ecc_col = 6'h29;
            5'd14: ecc_col = 6'h2A;
            5'd15: ecc_col = 6'h2C;
            5'd16: ecc_col = 6'h31;
            5'd17: ecc_col = 6'h32;
            5'd18: ecc_col = 6'h34;
            5'd19: ecc_col = 6'h38;
            5'd20: ecc_col = 6'h1F;
            5'd21: ecc_col = 6'h2F;
            5'd22: ecc_col = 6'h37;
            5'd23: ecc_col = 6'h3B;
            default: ecc_col = 6'h00;
        endcase
    endfunction

    function automatic logic [5:0] ecc_parity(input logic [23:0] d);
        logic [5:0] p;
        p = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) p = p ^ ecc_col(5'(i));
        end
        return p;
    endfunction

    // One byte of the reflected CRC-16, least significant bit first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] n;
        logic        fb;
        n = c;
        for (int i = 0; i < 8; i++) begin
            fb = n[0] ^ b[i];
            n  = {1'b0, n[15:1]};
            if (fb) n = n ^ 16'h8408;
        end
        return n;
    endfunction

    // Header check: syndrome, optional single-bit correction, error classification.
    always_comb begin
        hdr_d = {wch_r, wcl_r, di_r};
        syn   = ecc_parity(hdr_d) ^ ecc_r[5:0];
`ifdef CSI2_ECC_CORRECT_EN
        begin
            logic col_hit;
            col_hit = 1'b0;
            chk_hdr = hdr_d;
            for (int i = 0; i < 24; i++) begin
                if (syn == ecc_col(5'(i))) begin
                    col_hit    = 1'b1;
                    chk_hdr[i] = ~hdr_d[i];
                end
            end
            chk_err1 = col_hit | $onehot(syn);
            chk_err2 = (syn != 6'h00) && !col_hit && !$onehot(syn);
        end
`else
        chk_hdr  = hdr_d;
        chk_err1 = 1'b0;
        chk_err2 = (syn != 6'h00);
`endif
        chk_err2 = chk_err2 | (ecc_r[7:6] != 2'b00)
                 | ({1'b0, chk_hdr[23:8]} > {1'b0, MAX_WC});
    end

    // Packet state machine with registered outputs; pkt_start always restarts the header.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            hdr_idx     <= 2'd0;
            di_r        <= 8'h00;
            wcl_r       <= 8'h00;
            wch_r       <= 8'h00;
            ecc_r       <= 8'h00;
            crc_lo_r    <= 8'h00;
            crc_r       <= 16'hFFFF;
            byte_cnt    <= 17'd0;
            vc          <= 2'd0;
            id          <= 8'hFF;
            wc          <= 16'h0000;
            data_in_llp <= 8'h00;
            data_valid  <= 1'b0;
            ecc_error1  <= 1'b0;
            ecc_error2  <= 1'b0;
            crc_detect  <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            if (byte_valid && pkt_start) begin
                di_r    <= byte_in;
                hdr_idx <= 2'd0;
                crc_r   <= 16'hFFFF;
                state   <= S_HDR;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_HDR: begin
                        if (byte_valid) begin
                            case (hdr_idx)
                                2'd0: begin
                                    wcl_r   <= byte_in;
                                    hdr_idx <= 2'd1;
                                end
                                2'd1: begin
                                    wch_r   <= byte_in;
                                    hdr_idx <= 2'd2;
                                end
                                default: begin
                                    ecc_r <= byte_in;
                                    state <= S_CHECK;
                                end
                            endcase
                        end
                    end
                    S_CHECK: begin
                        vc         <= chk_hdr[7:6];
                        id         <= {2'b00, chk_hdr[5:0]};
                        wc         <= chk_hdr[23:8];
                        ecc_error1 <= chk_err1;
                        ecc_error2 <= chk_err2;
                        crc_detect <= 1'b0;
                        byte_cnt   <= 17'd0;
                        if (chk_hdr[5:0] <= 6'h0F) begin
                            state    <= S_DONE;
                            pkt_done <= 1'b1;
                        end else if (chk_hdr[23:8] == 16'h0000) begin
                            state <= S_CRC_LO;
                        end else if (chk_err2) begin
                            state    <= S_DONE;
                            pkt_done <= 1'b1;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (byte_valid) begin
                            data_in_llp <= byte_in;
                            data_valid  <= 1'b1;
                            crc_r       <= crc_byte(crc_r, byte_in);
                            byte_cnt    <= byte_cnt + 17'd1;
                            if (byte_cnt + 17'd1 == {1'b0, wc}) state <= S_CRC_LO;
                        end
                    end
                    S_CRC_LO: begin
                        if (byte_valid) begin
                            crc_lo_r <= byte_in;
                            state    <= S_CRC_HI;
                        end
                    end
                    S_CRC_HI: begin
                        if (byte_valid) begin
                            crc_detect <= ({byte_in, crc_lo_r} != crc_r);
                            state      <= S_DONE;
                            pkt_done   <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        crc_r <= 16'hFFFF;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi2_llp_packet_parser.sv
// Bench for csi2_llp_packet_parser: vector table of short-packet headers,
// directed long-packet sequences, and randomized packets checked against a
// reference model of the header ECC and payload CRC rules.
module tb_csi2_llp_packet_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        pkt_start;
    logic [1:0]  vc;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [7:0]  data_in_llp;
    logic        data_valid;
    logic        ecc_error1;
    logic        ecc_error2;
    logic        crc_detect;
    logic        pkt_done;

    csi2_llp_packet_parser dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .pkt_start(pkt_start), .vc(vc), .id(id), .wc(wc), .data_in_llp(data_in_llp),
        .data_valid(data_valid), .ecc_error1(ecc_error1), .ecc_error2(ecc_error2),
        .crc_detect(crc_detect), .pkt_done(pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_edge = 0;
    logic [1:0]  snap_vc;
    logic [7:0]  snap_id;
    logic [15:0] snap_wc;
    logic        snap_e1, snap_e2, snap_crc;
    logic [7:0]  obs_data[$];
    int          obs_edge[$];
    logic [7:0]  pl[$];

    always @(posedge clk) cyc++;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            obs_data.push_back(data_in_llp);
            obs_edge.push_back(cyc);
        end
        if (pkt_done) begin
            done_cnt++;
            done_edge = cyc;
            snap_vc = vc; snap_id = id; snap_wc = wc;
            snap_e1 = ecc_error1; snap_e2 = ecc_error2; snap_crc = crc_detect;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [5:0] m_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [15:0] m_crc();
        int unsigned c;
        c = 32'hFFFF;
        foreach (pl[k]) begin
            c = c ^ 32'(pl[k]);
            for (int b = 0; b < 8; b++) c = (c & 32'd1) != 0 ? ((c >> 1) ^ 32'h8408) : (c >> 1);
        end
        return c[15:0];
    endfunction

    // Expected header after checking: search for a single flipped data bit that explains the ECC.
    task automatic m_hdr(input logic [23:0] d, input logic [7:0] e,
                         output logic [23:0] fx, output logic e1, output logic e2);
        logic [5:0] s;
        s  = m_ecc(d) ^ e[5:0];
        fx = d; e1 = 1'b0; e2 = 1'b0;
        if (s != 6'h00) begin
`ifdef CSI2_ECC_CORRECT_EN
            logic found;
            found = ($countones(s) == 1);
            for (int i = 0; i < 24; i++) begin
                if (m_ecc(d ^ (24'h1 << i)) == e[5:0]) begin
                    fx = d ^ (24'h1 << i);
                    found = 1'b1;
                end
            end
            if (found) e1 = 1'b1; else e2 = 1'b1;
`else
            e2 = 1'b1;
`endif
        end
        if (e[7:6] != 2'b00) e2 = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic gap(input int mx);
        if (mx > 0) idle(int'($urandom_range(0, mx)));
    endtask

    task automatic drive(input logic [7:0] b, input logic st, output int e);
        byte_in = b; byte_valid = 1'b1; pkt_start = st;
        @(posedge clk); #1;
        e = cyc;
        byte_valid = 1'b0;
        pkt_start = 1'($urandom_range(0, 1));
        byte_in = 8'($urandom);
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while (done_cnt < target && i < 60) begin
            @(posedge clk); #1;
            i++;
        end
        idle(3);
    endtask

    task automatic send_packet(input string tag, input logic [7:0] di, input logic [15:0] wcv,
                               input logic [23:0] dflip, input logic [7:0] exor,
                               input logic [15:0] cxor, input int gapmax, input int gap_at);
        logic [23:0] hdr, sh, fx;
        logic [7:0]  se;
        logic        e1, e2, lng, deliver, crc_path, exp_crc;
        logic [15:0] true_crc, sent_crc;
        int          done0, e, e_ecc, n;
        logic [7:0]  ed[$];
        int          ee[$];
        hdr = {wcv, di};
        se  = {2'b00, m_ecc(hdr)} ^ exor;
        sh  = hdr ^ dflip;
        m_hdr(sh, se, fx, e1, e2);
        lng      = (fx[5:0] > 6'h0F);
        deliver  = lng && (fx[23:8] != 16'h0000) && !e2;
        crc_path = lng && ((fx[23:8] == 16'h0000) || !e2);
        true_crc = m_crc();
        sent_crc = true_crc ^ cxor;
        exp_crc  = crc_path && (sent_crc != true_crc);
        obs_data.delete(); obs_edge.delete();
        done0 = done_cnt;
        gap(gapmax); drive(sh[7:0], 1'b1, e);
        gap(gapmax); drive(sh[15:8], 1'b0, e);
        gap(gapmax); drive(sh[23:16], 1'b0, e);
        gap(gapmax); drive(se, 1'b0, e_ecc);
        idle(1);
        if (di[5:0] > 6'h0F) begin
            foreach (pl[k]) begin
                if (k == gap_at) idle(3);
                gap(gapmax);
                drive(pl[k], 1'b0, e);
                if (deliver) begin
                    ed.push_back(pl[k]);
                    ee.push_back(e);
                end
            end
            gap(gapmax); drive(sent_crc[7:0], 1'b0, e);
            gap(gapmax); drive(sent_crc[15:8], 1'b0, e);
        end
        wait_done(done0 + 1);
        check({tag, " pkt_done count"}, 32'(done_cnt), 32'(done0 + 1));
        if (!crc_path) check({tag, " pkt_done latency"}, 32'(done_edge), 32'(e_ecc + 1));
        check({tag, " vc"}, 32'(snap_vc), 32'(fx[7:6]));
        check({tag, " id"}, 32'(snap_id), {26'd0, fx[5:0]});
        check({tag, " wc"}, 32'(snap_wc), 32'(fx[23:8]));
        check({tag, " ecc_error1"}, 32'(snap_e1), 32'(e1));
        check({tag, " ecc_error2"}, 32'(snap_e2), 32'(e2));
        check({tag, " crc_detect"}, 32'(snap_crc), 32'(exp_crc));
        check({tag, " payload count"}, 32'(obs_data.size()), 32'(ed.size()));
        n = (obs_data.size() < ed.size()) ? obs_data.size() : ed.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s byte%0d", tag, k), 32'(obs_data[k]), 32'(ed[k]));
            check($sformatf("%s byte%0d cycle", tag, k), 32'(obs_edge[k]), 32'(ee[k]));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  di, wl, wh, ecc;
        logic [1:0]  v;
        logic [7:0]  i;
        logic [15:0] w;
        logic        e1, e2;
    } vec_t;

    vec_t tbl[8];

    task automatic send_raw_short(input int idx, input vec_t t);
        int done0, e, e_ecc;
        string tag;
        tag = $sformatf("tbl%0d", idx);
        obs_data.delete(); obs_edge.delete();
        done0 = done_cnt;
        drive(t.di, 1'b1, e);
        drive(t.wl, 1'b0, e);
        drive(t.wh, 1'b0, e);
        drive(t.ecc, 1'b0, e_ecc);
        wait_done(done0 + 1);
        check({tag, " pkt_done count"}, 32'(done_cnt), 32'(done0 + 1));
        check({tag, " pkt_done latency"}, 32'(done_edge), 32'(e_ecc + 1));
        check({tag, " vc"}, 32'(snap_vc), 32'(t.v));
        check({tag, " id"}, 32'(snap_id), 32'(t.i));
        check({tag, " wc"}, 32'(snap_wc), 32'(t.w));
        check({tag, " ecc_error1"}, 32'(snap_e1), 32'(t.e1));
        check({tag, " ecc_error2"}, 32'(snap_e2), 32'(t.e2));
        check({tag, " crc_detect"}, 32'(snap_crc), 32'd0);
        check({tag, " no payload"}, 32'(obs_data.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  dts[5];
        logic [7:0]  di;
        logic [15:0] wcv;
        logic [23:0] dflip;
        logic [7:0]  exor;
        logic [15:0] cxor;
        int          e, done0, a, b;

        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 16'h0000, 1'b0, 1'b0};
`ifdef CSI2_ECC_CORRECT_EN
        tbl[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{8'h41, 8'h34, 8'h12, 8'h11, 2'd1, 8'h01, 16'h1234, 1'b1, 1'b0};
        tbl[6] = '{8'h41, 8'h34, 8'h92, 8'h10, 2'd1, 8'h01, 16'h1234, 1'b1, 1'b0};
`else
        tbl[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 8'h01, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{8'h41, 8'h34, 8'h12, 8'h11, 2'd1, 8'h01, 16'h1234, 1'b0, 1'b1};
        tbl[6] = '{8'h41, 8'h34, 8'h92, 8'h10, 2'd1, 8'h01, 16'h9234, 1'b0, 1'b1};
`endif
        tbl[2] = '{8'h41, 8'h34, 8'h12, 8'h10, 2'd1, 8'h01, 16'h1234, 1'b0, 1'b0};
        tbl[4] = '{8'h41, 8'h34, 8'h12, 8'h90, 2'd1, 8'h01, 16'h1234, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h03, 2'd0, 8'h00, 16'h0000, 1'b0, 1'b1};
        tbl[7] = '{8'hC0, 8'h00, 8'h00, 8'h0F, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b0};

        reset = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; pkt_start = 1'b0;
        idle(3);
        check("reset id", 32'(id), 32'hFF);
        check("reset vc/wc", {14'd0, vc, wc}, 32'd0);
        check("reset outputs", {26'd0, data_valid, ecc_error1, ecc_error2, crc_detect, pkt_done, 1'b0}, 32'd0);
        reset = 1'b1;
        idle(2);
        check("idle id", 32'(id), 32'hFF);

        for (int i = 0; i < 8; i++) begin
            send_raw_short(i, tbl[i]);
            idle(2);
        end

        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_packet("raw8", 8'h6A, 16'd4, 24'h0, 8'h00, 16'h0000, 0, -1);
        idle(2);
        send_packet("raw8 badcrc", 8'h6A, 16'd4, 24'h0, 8'h00, 16'h0001, 0, -1);
        idle(2);
        pl = '{8'h5A, 8'hA5, 8'h01, 8'hFE, 8'h7E};
        send_packet("raw10 stall", 8'h2B, 16'd5, 24'h0, 8'h00, 16'h0000, 0, 2);
        idle(2);
        pl.delete();
        send_packet("long wc0", 8'h2A, 16'd0, 24'h0, 8'h00, 16'h0000, 0, -1);
        idle(2);
        pl = '{8'h10, 8'h20, 8'h30};
        send_packet("long ecc fatal", 8'h2A, 16'd3, 24'h0, 8'h80, 16'h0000, 0, -1);
        idle(2);

        // Abort: a new pkt_start mid-payload restarts the header; only one pkt_done.
        obs_data.delete(); obs_edge.delete();
        done0 = done_cnt;
        drive(8'h2A, 1'b1, e); drive(8'h06, 1'b0, e); drive(8'h00, 1'b0, e);
        drive({2'b00, m_ecc(24'h00062A)}, 1'b0, e);
        idle(1);
        drive(8'hAB, 1'b0, e); drive(8'hCD, 1'b0, e);
        drive(8'h00, 1'b1, e); drive(8'h00, 1'b0, e); drive(8'h00, 1'b0, e); drive(8'h00, 1'b0, e);
        wait_done(done0 + 1);
        check("abort pkt_done count", 32'(done_cnt), 32'(done0 + 1));
        check("abort id", 32'(snap_id), 32'h00);
        check("abort wc", 32'(snap_wc), 32'h0000);
        check("abort payload before restart", 32'(obs_data.size()), 32'd2);
        idle(2);

        dts = '{8'h2A, 8'h2B, 8'h1E, 8'h05, 8'h12};
        for (int n = 0; n < 40; n++) begin
            di = {2'($urandom_range(0, 3)), dts[$urandom_range(0, 4)][5:0]};
            pl.delete();
            if (di[5:0] > 6'h0F) begin
                wcv = 16'($urandom_range(0, 10));
                repeat (int'(wcv)) pl.push_back(8'($urandom));
            end else begin
                wcv = 16'($urandom);
            end
            dflip = 24'h0; exor = 8'h00; cxor = 16'h0000;
            case ($urandom_range(0, 9))
                5: exor = 8'(1 << $urandom_range(0, 5));
                6: begin
                    a = int'($urandom_range(0, 5));
                    b = (a + 1 + int'($urandom_range(0, 4))) % 6;
                    exor = 8'((1 << a) | (1 << b));
                end
                7: exor = 8'(8'h40 << $urandom_range(0, 1));
                8: cxor = 16'(1 << $urandom_range(0, 15));
`ifdef CSI2_ECC_CORRECT_EN
                9: dflip = 24'(1 << $urandom_range(0, 23));
`else
                9: cxor = 16'h8000;
`endif
                default: ;
            endcase
            send_packet($sformatf("rnd%0d", n), di, wcv, dflip, exor, cxor,
                        int'($urandom_range(0, 2)), -1);
            idle(int'($urandom_range(1, 3)));
        end

        // Reset asserted while the second payload byte is being presented.
        pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        done0 = done_cnt;
        drive(8'h6A, 1'b1, e); drive(8'h04, 1'b0, e); drive(8'h00, 1'b0, e);
        drive({2'b00, m_ecc(24'h00046A)}, 1'b0, e);
        idle(1);
        drive(8'hA1, 1'b0, e);
        byte_in = 8'hB2; byte_valid = 1'b1; pkt_start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("midreset id", 32'(id), 32'hFF);
        check("midreset vc/wc", {14'd0, vc, wc}, 32'd0);
        check("midreset data", 32'(data_in_llp), 32'd0);
        check("midreset flags", {27'd0, data_valid, ecc_error1, ecc_error2, crc_detect, pkt_done}, 32'd0);
        byte_valid = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(2);
        check("midreset no pkt_done", 32'(done_cnt), 32'(done0));
        pl.delete();
        send_packet("after reset", 8'h00, 16'h0000, 24'h0, 8'h00, 16'h0000, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
